parity_frame_checker: RTL and testbench
=======================================

// Module: parity_frame_checker
// PURPOSE
//   Serial parity checker that sits directly downstream of the serial parity generator.
//   Receives a qualified serial bit stream framed as DATA_BITS data bits followed by one parity bit.
//   Deserialises the data, recomputes running parity and reports each frame with a pass/fail flag.
//   Feeds the parallel consumer and the link status/error logic.
// PARAMETERS
//   DATA_BITS   8  data bits per frame (>=1); the parity bit follows immediately after them
//   ODD_PARITY  0  0: even parity expected; 1: odd parity expected
//   CNT_W       8  width of error counter (used only with PARITY_ERR_CNT_EN)
// PORTS
//   clk          in   1          rising-edge clock, single clock domain
//   rst          in   1          asynchronous, active-high reset
//   x            in   1          serial bit, sampled only when x_valid=1
//   x_valid      in   1          bit qualifier; idle cycles (x_valid=0) may occur anywhere
//   sof          in   1          start of frame; with x_valid=1, marks x as data bit 0
//   data_out     out  DATA_BITS  last completed frame's data, LSB = first bit received
//   frame_valid  out  1          one-cycle pulse: data_out/parity_err valid
//   parity_err   out  1          valid with frame_valid: 1 = parity mismatch
//   frame_abort  out  1          one-cycle pulse: frame in progress discarded by resync sof
//   busy         out  1          1 while in DATA or PARITY state
//   err_clr      in   1          (PARITY_ERR_CNT_EN only) synchronous counter clear
//   err_count    out  CNT_W      (PARITY_ERR_CNT_EN only) saturating parity-error count
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, bit count=0, running parity=0, data_out=0,
//     frame_valid=0, parity_err=0, frame_abort=0, busy=0, err_count=0. Reset mid-frame discards it.
//   All outputs are registered; nothing is combinational from inputs.
//   Running parity: toggles on each accepted data bit equal to 1 (same rule as the generator).
//   FSM (transitions only on cycles with x_valid=1; x_valid=0 holds all state):
//     IDLE:   sof=1 -> shift x into bit 0, parity=x, count=1; go DATA (PARITY if DATA_BITS=1).
//             sof=0 -> bit ignored, stay IDLE (stray bits between frames are dropped silently).
//     DATA:   sof=0 -> shift x in at position count, update parity, count++;
//             count reaches DATA_BITS -> PARITY.
//             sof=1 -> resync: pulse frame_abort next cycle, restart frame with x as bit 0.
//     PARITY: sof=0 -> compare: err = x ^ parity ^ ODD_PARITY; next cycle data_out<=shift reg,
//             parity_err<=err, frame_valid=1; go IDLE.
//             sof=1 -> resync exactly as in DATA (no frame_valid for the broken frame).
//   Latency: frame_valid rises on the clock edge after the parity bit is sampled.
//   Back-to-back: sof for the next frame is accepted in the cycle right after the parity bit
//     (the cycle frame_valid is high); no gap is required.
//   data_out and parity_err hold their values until the next frame_valid; both are 0 after reset.
//   frame_valid and frame_abort are never high in the same cycle.
// CONFIGURATION
//   PARITY_ERR_CNT_EN defined: err_clr/err_count ports exist; err_count increments when a frame
//     completes with parity_err=1, saturates at 2^CNT_W-1; err_clr has priority over increment.
//   Not defined: ports, counter and CNT_W logic are absent; all other behaviour identical.
// STRUCTURE
//   Shared package parity_pkg: FSM state encodings (IDLE/DATA/PARITY), EVEN/ODD parity constants,
//     shared with the parity generator.
//   One sub-module: parity_accum (1-bit toggle register with clear/load/enable), also reusable
//     on the generator side. Shift register, counter and FSM stay in the top module.
// TESTING
//   1. DATA_BITS=8 even; bits 1,0,1,1,0,0,0,0 (sof on first) then parity 1 ->
//      frame_valid pulse, data_out=8'h0D, parity_err=0.
//   2. Same data, parity bit 0 -> data_out=8'h0D, parity_err=1; err_count 0->1 (with macro).
//   3. Frame 1 interleaved with random x_valid=0 gaps, then frame 2 sof the cycle after
//      frame 1 parity -> two frame_valid pulses, correct data for both, no abort.
//   4. sof reasserted at data bit 5 -> frame_abort pulse, no frame_valid; following 8 bits + parity
//      decoded as a full new frame.
//   5. rst asserted asynchronously mid-DATA -> all outputs 0 immediately, busy=0; next sof frame OK.
//   6. ODD_PARITY=1, data 8'hFF with parity 1 -> parity_err=0; CNT_W=2 with 5 bad frames ->
//      err_count saturates at 3; err_clr -> 0.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: FSM state encodings and parity sense constants shared by the parity generator and checker
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  localparam logic EVEN = 1'b0;
  localparam logic ODD = 1'b1;
endpackage

// File: rtl/parity_accum.sv
// parity_accum: 1-bit running-parity toggle register
// Ports: clk, rst (async, high); clr zeroes q; load sets q=d; en toggles q when d=1; q = running parity
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic d,
  output logic q
);
  logic q_q, q_d;
  always_comb q_d = clr ? 1'b0 : load ? d : en ? q_q ^ d : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= 1'b0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: deserialises DATA_BITS data bits plus one parity bit and flags parity mismatches
// Ports: clk, rst (async, high); x/x_valid/sof serial input; data_out, frame_valid, parity_err,
// frame_abort, busy registered outputs; err_clr/err_count exist only with PARITY_ERR_CNT_EN defined
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 sof,
`ifdef PARITY_ERR_CNT_EN
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_count,
`endif
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 frame_abort,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic fv_q, fv_d, perr_q, perr_d, fa_q, fa_d;
  logic par, acc_clr, acc_load, acc_en;
  parity_accum u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .load(acc_load),
    .en  (acc_en),
    .d   (x),
    .q   (par)
  );
  // Bits enter at the MSB and shift down, so the first bit lands at the LSB after DATA_BITS shifts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    data_d   = data_q;
    perr_d   = perr_q;
    fv_d     = 1'b0;
    fa_d     = 1'b0;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    if (x_valid && sof) begin
      fa_d     = state_q != IDLE;
      sh_d     = DATA_BITS'({x, {DATA_BITS{1'b0}}} >> 1);
      cnt_d    = CW'(1);
      acc_load = 1'b1;
      state_d  = DATA_BITS == 1 ? PARITY : DATA;
    end else if (x_valid && state_q == DATA) begin
      sh_d    = DATA_BITS'({x, sh_q} >> 1);
      cnt_d   = cnt_q + CW'(1);
      acc_en  = 1'b1;
      state_d = cnt_q == CW'(DATA_BITS - 1) ? PARITY : DATA;
    end else if (x_valid && state_q == PARITY) begin
      fv_d    = 1'b1;
      data_d  = sh_q;
      perr_d  = x ^ par ^ ((ODD_PARITY != 0) ? ODD : EVEN);
      cnt_d   = '0;
      acc_clr = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fv_q    <= 1'b0;
      fa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
    end
  assign data_out    = data_q;
  assign frame_valid = fv_q;
  assign parity_err  = perr_q;
  assign frame_abort = fa_q;
  assign busy        = state_q != IDLE;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_q, err_d;
  always_comb err_d = err_clr ? '0 : (fv_d && perr_d && err_q != '1) ? err_q + CNT_W'(1) : err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= '0;
    else err_q <= err_d;
  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: directed checks of the frame checker, even (8-bit) and odd (8-bit) instances
module tb_parity_frame_checker;
  logic clk = 1'b0, rst = 1'b1, x = 1'b0, x_valid = 1'b0, sof = 1'b0;
  logic [7:0] data_e, data_o;
  logic fv_e, pe_e, fa_e, busy_e, fv_o, pe_o, fa_o, busy_o;
`ifdef PARITY_ERR_CNT_EN
  logic clr = 1'b0;
  logic [7:0] cnt_e;
  logic [1:0] cnt_o;
`endif
  int n_chk = 0, n_err = 0, n_fv = 0, n_fa = 0, n_both = 0;
  logic [7:0] got_q[$];
  logic [7:0] d;
  always #5 clk = ~clk;
  parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0)
`ifdef PARITY_ERR_CNT_EN
    , .CNT_W(8)
`endif
  ) dut_e (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
`ifdef PARITY_ERR_CNT_EN
    .err_clr(clr), .err_count(cnt_e),
`endif
    .data_out(data_e), .frame_valid(fv_e), .parity_err(pe_e), .frame_abort(fa_e), .busy(busy_e)
  );
  parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(1)
`ifdef PARITY_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) dut_o (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
`ifdef PARITY_ERR_CNT_EN
    .err_clr(clr), .err_count(cnt_o),
`endif
    .data_out(data_o), .frame_valid(fv_o), .parity_err(pe_o), .frame_abort(fa_o), .busy(busy_o)
  );
  always @(negedge clk) begin
    if (fv_e) begin
      n_fv++;
      got_q.push_back(data_e);
    end
    if (fa_e) n_fa++;
    if (fv_e && fa_e) n_both++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic b, input logic s);
    x = b;
    sof = s;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    sof = 1'b0;
    x = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic frame(input logic [7:0] v, input logic p, input int gap);
    for (int i = 0; i < 8; i++) begin
      put(v[i], i == 0);
      if (gap > 0) idle(int'($urandom_range(0, gap)));
    end
    put(p, 1'b0);
  endtask
  initial begin
    idle(2);
    check("rst_data", data_e, 0);
    check("rst_fv", fv_e, 0);
    check("rst_pe", pe_e, 0);
    check("rst_fa", fa_e, 0);
    check("rst_busy", busy_e, 0);
    rst = 1'b0;
    idle(1);
    put(1'b1, 1'b0);
    put(1'b1, 1'b0);
    check("stray_busy", busy_e, 0);
    check("stray_fv", n_fv, 0);
    frame(8'h0D, 1'b1, 0);
    check("t1_fv", fv_e, 1);
    check("t1_data", data_e, 8'h0D);
    check("t1_pe", pe_e, 0);
    check("t1_busy", busy_e, 0);
    check("t1_odd_pe", pe_o, 1);
    idle(1);
    check("t1_pulse", fv_e, 0);
    check("t1_hold", data_e, 8'h0D);
    frame(8'h0D, 1'b0, 0);
    check("t2_data", data_e, 8'h0D);
    check("t2_pe", pe_e, 1);
    check("t2_odd_pe", pe_o, 0);
`ifdef PARITY_ERR_CNT_EN
    check("t2_cnt", cnt_e, 1);
`endif
    idle(1);
    n_fv = 0;
    n_fa = 0;
    got_q.delete();
    frame(8'hA5, 1'b0, 2);
    frame(8'h3C, 1'b0, 0);
    check("t3_fv", fv_e, 1);
    check("t3_pe", pe_e, 0);
    idle(2);
    check("t3_nfv", n_fv, 2);
    check("t3_nfa", n_fa, 0);
    check("t3_n", got_q.size(), 2);
    check("t3_d0", got_q[0], 8'hA5);
    check("t3_d1", got_q[1], 8'h3C);
    n_fv = 0;
    n_fa = 0;
    n_both = 0;
    got_q.delete();
    for (int i = 0; i < 5; i++) put(1'b1, i == 0);
    check("t4_busy", busy_e, 1);
    d = 8'h96;
    put(d[0], 1'b1);
    check("t4_fa", fa_e, 1);
    check("t4_nofv", fv_e, 0);
    for (int i = 1; i < 8; i++) put(d[i], 1'b0);
    put(1'b0, 1'b0);
    check("t4_fv", fv_e, 1);
    check("t4_data", data_e, 8'h96);
    check("t4_pe", pe_e, 0);
    idle(1);
    check("t4_nfa", n_fa, 1);
    check("t4_nfv", n_fv, 1);
    check("t4_both", n_both, 0);
    put(1'b1, 1'b1);
    put(1'b1, 1'b0);
    put(1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_data", data_e, 0);
    check("t5_busy", busy_e, 0);
    check("t5_pe", pe_e, 0);
    check("t5_fv", fv_e, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_idle", busy_e, 0);
    frame(8'h81, 1'b0, 0);
    check("t5_fv2", fv_e, 1);
    check("t5_data2", data_e, 8'h81);
    check("t5_pe2", pe_e, 0);
    frame(8'hFF, 1'b1, 0);
    check("t6_odd_data", data_o, 8'hFF);
    check("t6_odd_pe", pe_o, 0);
    check("t6_even_pe", pe_e, 1);
`ifdef PARITY_ERR_CNT_EN
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("t6_clr0", cnt_o, 0);
    repeat (5) frame(8'hFF, 1'b0, 0);
    check("t6_sat", cnt_o, 3);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("t6_clr", cnt_o, 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
